gray_step_counter: RTL and testbench
====================================

GRAY_STEP_COUNTER -- requirements
Module: gray_step_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits; legal range is 2..16.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port up_pulse, input, 1, a step-up request from the upstream debounce stage.
REQ-005 The block SHALL have port down_pulse, input, 1, a step-down request from a second debounce stage.
REQ-006 The block SHALL have port clear, input, 1, a request to return the count to zero.
REQ-007 The block SHALL have port gray, output, WIDTH, the registered Gray-coded count.
REQ-008 The block SHALL have port bin, output, WIDTH, the registered binary equivalent of gray.
REQ-009 The block SHALL have port step, output, 1, a one-cycle pulse in the cycle gray takes a new stepped value.
REQ-010 The block SHALL have port wrap, output, 1, a one-cycle pulse when a step crosses the max/0 boundary in either direction.
REQ-011 The block SHALL have port changed_bit, output, clog2(WIDTH), the index of the gray bit that toggled on the last step, held between steps.

Function
REQ-012 The block SHALL rising-edge-detect up_pulse and down_pulse, so a request held high for N cycles counts exactly once.
REQ-013 An edge registered in cycle t SHALL make gray, bin, step, wrap and changed_bit reflect the step in cycle t+1, giving 1-cycle latency.
REQ-014 An up edge SHALL compute bin_next = bin + 1 mod 2^WIDTH, and a down edge SHALL compute bin_next = bin - 1 mod 2^WIDTH.
REQ-015 gray SHALL always equal bin XOR (bin >> 1); no other gray encoding is permitted.
REQ-016 Up from 2^WIDTH-1 to 0 and down from 0 to 2^WIDTH-1 SHALL assert wrap together with step.
REQ-017 changed_bit SHALL equal the index of the single set bit of (gray_old XOR gray_new) on every step.
REQ-018 Up and down edges in the same cycle SHALL cancel: no count change, step=0, wrap=0.
REQ-019 clear SHALL be level-sensitive and SHALL have priority over the edges.
REQ-020 When clear is asserted, bin and gray SHALL become 0, step=0, wrap=0 and changed_bit=0; edges arriving in that cycle are discarded.
REQ-021 While the block is idle, gray, bin and changed_bit SHALL hold, and step and wrap SHALL be 0.
REQ-022 step and wrap SHALL never be high for two consecutive cycles without two distinct edges.

Reset
REQ-023 When reset is asserted, gray=0, bin=0, step=0, wrap=0 and changed_bit=0.
REQ-024 When reset is asserted, the edge-detect history registers SHALL reset to 1, so an input already high at reset release does not cause a step.
REQ-025 Reset asserted mid-operation SHALL abort any pending edge; the count restarts at 0 the cycle after reset deasserts.
REQ-026 Reset SHALL have priority over clear and over both edges.

Structure
REQ-027 The shared package SHALL hold the default WIDTH constant and the bin-to-gray function.
REQ-028 The shared package SHALL also hold the function that maps a one-hot vector to its bit index.
REQ-029 Rising-edge detection SHALL be a sub-module named edge_detect, instantiated twice, with its history register reset to 1.
REQ-030 The count register, the step/wrap/changed_bit logic and the clear/cancel priority SHALL live in gray_step_counter itself.

Verification (WIDTH=4)
REQ-031 Scenario: 16 single-cycle up_pulse -> gray steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0; wrap=1 only on the 16th step.
REQ-032 Scenario: from reset, one down_pulse -> bin=F, gray=8, wrap=1, changed_bit=3, step=1 one cycle after the pulse.
REQ-033 Scenario: up_pulse held high for 50 cycles -> exactly one step; bin=1, gray=1, changed_bit=0.
REQ-034 Scenario: at bin=5, up_pulse and down_pulse edges in the same cycle -> bin stays 5, step=0.
REQ-035 Scenario: at bin=7, clear and up_pulse edge in the same cycle -> bin=0, gray=0, step=0, changed_bit=0.
REQ-036 Scenario: up_pulse high during reset and held after release -> no step until up_pulse goes low then high again.

Source files
------------

// File: rtl/gray_step_counter_pkg.sv
// Shared constants and combinational helpers for the Gray-coded step counter.
package gray_step_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;
    localparam int IDX_W         = $clog2(MAX_WIDTH);

    // Reflected binary Gray code; callers zero-extend narrower counts.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_index(input logic [MAX_WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gray_step_counter_edge_detect.sv
// Rising-edge detector; history resets high so a level already present at reset release is ignored.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (reset) hist <= 1'b1;
        else       hist <= sig;
    end

    assign rise = sig & ~hist;

endmodule

// File: rtl/gray_step_counter.sv
// Up/down step counter holding a binary count and its Gray code, with step/wrap pulses and toggled-bit index.
module gray_step_counter
    import gray_step_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       up_pulse,
    input  logic                       down_pulse,
    input  logic                       clear,
    output logic [WIDTH-1:0]           gray,
    output logic [WIDTH-1:0]           bin,
    output logic                       step,
    output logic                       wrap,
    output logic [$clog2(WIDTH)-1:0]   changed_bit
);

    localparam int CBW = $clog2(WIDTH);

    logic                 up_rise;
    logic                 down_rise;
    logic [WIDTH-1:0]     bin_next;
    logic                 do_step;
    logic                 do_wrap;
    logic [MAX_WIDTH-1:0] bin_ext;
    logic [MAX_WIDTH-1:0] gray_ext;
    logic [MAX_WIDTH-1:0] gray_next_full;
    logic [MAX_WIDTH-1:0] diff;
    logic [IDX_W-1:0]     idx_full;
    logic [CBW-1:0]       idx;
    logic                 unused_bits;

    edge_detect u_up_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (up_pulse),
        .rise  (up_rise)
    );

    edge_detect u_down_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (down_pulse),
        .rise  (down_rise)
    );

    always_comb begin
        bin_next = bin;
        do_step  = 1'b0;
        do_wrap  = 1'b0;
        // Simultaneous up and down edges cancel out.
        if (up_rise && !down_rise) begin
            bin_next = bin + WIDTH'(1);
            do_step  = 1'b1;
            do_wrap  = &bin;
        end else if (down_rise && !up_rise) begin
            bin_next = bin - WIDTH'(1);
            do_step  = 1'b1;
            do_wrap  = ~|bin;
        end

        bin_ext              = '0;
        bin_ext[WIDTH-1:0]   = bin_next;
        gray_next_full       = bin2gray(bin_ext);
        gray_ext             = '0;
        gray_ext[WIDTH-1:0]  = gray;
        diff                 = gray_ext ^ gray_next_full;
        idx_full             = onehot_index(diff);
        idx                  = idx_full[CBW-1:0];
    end

    // Upper bits are zero by construction for narrow counters.
    assign unused_bits = ^{gray_next_full, idx_full};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bin         <= '0;
            gray        <= '0;
            step        <= 1'b0;
            wrap        <= 1'b0;
            changed_bit <= '0;
        end else begin
            step <= do_step;
            wrap <= do_wrap;
            if (do_step) begin
                bin         <= bin_next;
                gray        <= gray_next_full[WIDTH-1:0];
                changed_bit <= idx;
            end
        end
    end

endmodule

// File: tb/tb_gray_step_counter.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural model, a monitor pops and compares.
module tb_gray_step_counter;

    logic       clk = 1'b0;
    logic       reset, up_pulse, down_pulse, clear;
    logic [3:0] gray, bin;
    logic       step, wrap;
    logic [1:0] changed_bit;

    gray_step_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .clear       (clear),
        .gray        (gray),
        .bin         (bin),
        .step        (step),
        .wrap        (wrap),
        .changed_bit (changed_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int bin;
        int gray;
        int step;
        int wrap;
        int cb;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Gray sequence for 4 bits, straight from the counting order.
    int gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    // Model state
    int m_cnt = 0, m_cb = 0, m_prev_up = 1, m_prev_dn = 1;

    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_entry cycle %0d: got %0d expected %0d", cyc, e.cyc, cyc);
            end else begin
                cmp("bin",         int'(bin),         e.bin);
                cmp("gray",        int'(gray),        e.gray);
                cmp("step",        int'(step),        e.step);
                cmp("wrap",        int'(wrap),        e.wrap);
                cmp("changed_bit", int'(changed_bit), e.cb);
            end
        end
    end

    // Apply inputs for one clock, predict the post-edge outputs, advance a cycle.
    task automatic cycle(input int r, input int c, input int u, input int d);
        exp_t e;
        int ue, de, old_cnt;
        reset      = r[0];
        clear      = c[0];
        up_pulse   = u[0];
        down_pulse = d[0];
        e.cyc  = cyc + 1;
        e.step = 0;
        e.wrap = 0;
        if (r != 0) begin
            m_cnt = 0; m_cb = 0; m_prev_up = 1; m_prev_dn = 1;
        end else begin
            ue = (u != 0 && m_prev_up == 0) ? 1 : 0;
            de = (d != 0 && m_prev_dn == 0) ? 1 : 0;
            m_prev_up = u; m_prev_dn = d;
            if (c != 0) begin
                m_cnt = 0; m_cb = 0;
            end else if (ue != de) begin
                old_cnt = m_cnt;
                if (ue != 0) begin
                    m_cnt  = (m_cnt + 1) % 16;
                    e.wrap = (old_cnt == 15) ? 1 : 0;
                end else begin
                    m_cnt  = (m_cnt + 15) % 16;
                    e.wrap = (old_cnt == 0) ? 1 : 0;
                end
                e.step = 1;
                m_cb   = $clog2(gtab[old_cnt] ^ gtab[m_cnt]);
            end
        end
        e.bin  = m_cnt;
        e.gray = gtab[m_cnt];
        e.cb   = m_cb;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic pulse_up(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 1, 0);
            cycle(0, 0, 0, 0);
        end
    endtask

    initial begin
        // Input already high through reset and after release: no step until re-armed.
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        idle(2);

        // Sixteen up steps through the full Gray sequence and the wrap.
        cycle(1, 0, 0, 0);
        pulse_up(16);
        idle(2);

        // Single down step from zero wraps to max.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        idle(2);

        // Long held request counts once.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) cycle(0, 0, 1, 0);
        idle(2);

        // Cancel at 5, then clear beats an up edge at 7.
        cycle(1, 0, 0, 0);
        pulse_up(5);
        cycle(0, 0, 1, 1);
        idle(2);
        pulse_up(2);
        cycle(0, 1, 1, 0);
        idle(2);

        // Reset mid-request aborts the pending edge.
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1 : 0,
                  ($urandom_range(0, 99) < 5) ? 1 : 0,
                  ($urandom_range(0, 99) < 45) ? 1 : 0,
                  ($urandom_range(0, 99) < 35) ? 1 : 0);
        end
        idle(3);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
